// File: rtl/mat_pkg.sv
// Shared definitions for the double-buffered matrix accumulator:
// default sizes, bank-state encoding and signed range helpers.
package mat_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ACC_W     = 16;
  localparam int DEF_ELEMS     = 9;
  localparam int DEF_NUM_TERMS = 3;

  // Life cycle of one accumulator bank
  typedef enum logic [1:0] {
    BANK_FREE    = 2'd0,
    BANK_FILLING = 2'd1,
    BANK_FULL    = 2'd2
  } bank_state_e;

  // Largest value representable in a w-bit two's-complement word
  function automatic longint signed_max(input int w);
    return (longint'(1) << (w - 1)) - 1;
  endfunction

  // Smallest value representable in a w-bit two's-complement word
  function automatic longint signed_min(input int w);
    return -(longint'(1) << (w - 1));
  endfunction

endpackage

// File: rtl/sat_add.sv
// Combinational signed adder ACC_W + DATA_W -> ACC_W that either clamps
// to the ACC_W signed range or wraps two's-complement.
module sat_add
  import mat_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ACC_W    = DEF_ACC_W,
  parameter int SATURATE = 1
) (
  input  logic signed [ACC_W-1:0]  i_a,
  input  logic signed [DATA_W-1:0] i_b,
  output logic signed [ACC_W-1:0]  o_sum
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(signed_max(ACC_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(signed_min(ACC_W));

  generate
    if (SATURATE != 0) begin : g_sat
      logic signed [ACC_W:0] w_a_ext;
      logic signed [ACC_W:0] w_b_ext;
      logic signed [ACC_W:0] w_sum;
      logic                  w_ovf;

      // One guard bit is enough: the sum of two ACC_W-range values fits in ACC_W+1
      assign w_a_ext = (ACC_W+1)'(i_a);
      assign w_b_ext = (ACC_W+1)'(i_b);
      assign w_sum   = w_a_ext + w_b_ext;
      assign w_ovf   = w_sum[ACC_W] ^ w_sum[ACC_W-1];

      // Clamp toward the sign of the true result when it leaves the range
      always_comb begin
        if (!w_ovf) begin
          o_sum = w_sum[ACC_W-1:0];
        end else if (w_sum[ACC_W]) begin
          o_sum = MIN_V;
        end else begin
          o_sum = MAX_V;
        end
      end
    end else begin : g_wrap
      assign o_sum = i_a + ACC_W'(i_b);
    end
  endgenerate

endmodule

// File: rtl/mat_accum_pp.sv
// Double-buffered matrix accumulator: sums NUM_TERMS matrices from the
// input stream into one bank while the other bank drains to the sink.
module mat_accum_pp
  import mat_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ACC_W     = DEF_ACC_W,
  parameter int ELEMS     = DEF_ELEMS,
  parameter int NUM_TERMS = DEF_NUM_TERMS,
  parameter int SATURATE  = 1
) (
  input  logic                     i_clk,
  input  logic                     i_clk_e,
  input  logic                     i_rst_n,
  input  logic signed [DATA_W-1:0] s_axis_data,
  input  logic                     s_axis_valid,
  output logic                     s_axis_ready,
  input  logic                     s_axis_last,
  output logic signed [ACC_W-1:0]  m_axis_res_data,
  output logic                     m_axis_res_valid,
  input  logic                     m_axis_res_ready,
  output logic                     m_axis_res_last,
  output logic                     o_err_len
);

  localparam int IDX_W  = $clog2(ELEMS);
  localparam int TERM_W = (NUM_TERMS > 1) ? $clog2(NUM_TERMS) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(ELEMS - 1);
  localparam logic [TERM_W-1:0] LAST_TERM = TERM_W'(NUM_TERMS - 1);

  logic signed [ACC_W-1:0] r_bank [2][ELEMS];
  logic [1:0]              r_full;
  logic                    r_wr_bank;
  logic                    r_rd_bank;
  logic [IDX_W-1:0]        r_wr_idx;
  logic [IDX_W-1:0]        r_rd_idx;
  logic [TERM_W-1:0]       r_term;
  logic                    r_err_len;

  bank_state_e             w_bank_state [2];
  logic                    w_in_acc;
  logic                    w_out_acc;
  logic                    w_wr_wrap;
  logic                    w_batch_done;
  logic                    w_rd_done;
  logic [1:0]              w_full_next;
  logic signed [ACC_W-1:0] w_acc_base;
  logic signed [ACC_W-1:0] w_acc_sum;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_state
      assign w_bank_state[gi] = r_full[gi]              ? BANK_FULL :
                                (r_wr_bank == 1'(gi))   ? BANK_FILLING :
                                                          BANK_FREE;
    end
  endgenerate

  assign s_axis_ready     = (w_bank_state[r_wr_bank] != BANK_FULL);
  assign m_axis_res_valid = (w_bank_state[r_rd_bank] == BANK_FULL);

  assign w_in_acc     = s_axis_valid & s_axis_ready & i_clk_e;
  assign w_out_acc    = m_axis_res_valid & m_axis_res_ready & i_clk_e;
  assign w_wr_wrap    = (r_wr_idx == LAST_IDX);
  assign w_batch_done = w_in_acc & w_wr_wrap & (r_term == LAST_TERM);
  assign w_rd_done    = w_out_acc & (r_rd_idx == LAST_IDX);

  // The first term of a batch adds onto zero, so it lands as a plain sign-extension
  assign w_acc_base = (r_term == '0) ? '0 : r_bank[r_wr_bank][r_wr_idx];

  sat_add #(
    .DATA_W   (DATA_W),
    .ACC_W    (ACC_W),
    .SATURATE (SATURATE)
  ) u_sat_add (
    .i_a   (w_acc_base),
    .i_b   (s_axis_data),
    .o_sum (w_acc_sum)
  );

  assign m_axis_res_data = m_axis_res_valid ? r_bank[r_rd_bank][r_rd_idx] : '0;
  assign m_axis_res_last = m_axis_res_valid & (r_rd_idx == LAST_IDX);
  assign o_err_len       = r_err_len;

  // Filling one bank and draining the other are independent, so both updates apply together
  always_comb begin
    w_full_next = r_full;
    if (w_batch_done) w_full_next[r_wr_bank] = 1'b1;
    if (w_rd_done)    w_full_next[r_rd_bank] = 1'b0;
  end

  // Bank storage holds data only; its contents are meaningless until a batch fills it
  always_ff @(posedge i_clk) begin
    if (w_in_acc) r_bank[r_wr_bank][r_wr_idx] <= w_acc_sum;
  end

  // Write/read pointers, bank full flags and the sticky framing error
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full    <= '0;
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_idx  <= '0;
      r_rd_idx  <= '0;
      r_term    <= '0;
      r_err_len <= 1'b0;
    end else begin
      r_full <= w_full_next;
      if (w_in_acc) begin
        // Framing follows the element counter only; last is merely checked
        if (s_axis_last != w_wr_wrap) r_err_len <= 1'b1;
        if (w_wr_wrap) begin
          r_wr_idx <= '0;
          if (r_term == LAST_TERM) begin
            r_term    <= '0;
            r_wr_bank <= ~r_wr_bank;
          end else begin
            r_term <= r_term + TERM_W'(1);
          end
        end else begin
          r_wr_idx <= r_wr_idx + IDX_W'(1);
        end
      end
      if (w_out_acc) begin
        if (r_rd_idx == LAST_IDX) begin
          r_rd_idx  <= '0;
          r_rd_bank <= ~r_rd_bank;
        end else begin
          r_rd_idx <= r_rd_idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mat_accum_pp.sv
// Self-checking bench: random and directed batches against a behavioural
// model of batch sums, with one 16-bit saturating instance and two 8-bit
// instances (saturating / wrapping) fed by the same stream.
module tb_mat_accum_pp;

  localparam int EL = 9;
  localparam int NT = 3;
  localparam int NB = EL * NT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic clk_e, rst_n, s_valid, s_last, r_ready;
  logic signed [7:0] s_data;
  logic s_ready, r_valid, r_last, err;
  logic signed [15:0] r_data;
  logic s_ready_a, r_valid_a, r_last_a, err_a;
  logic signed [7:0] r_data_a;
  logic s_ready_b, r_valid_b, r_last_b, err_b;
  logic signed [7:0] r_data_b;

  mat_accum_pp dut (
    .i_clk(clk), .i_clk_e(clk_e), .i_rst_n(rst_n),
    .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_ready(s_ready), .s_axis_last(s_last),
    .m_axis_res_data(r_data), .m_axis_res_valid(r_valid), .m_axis_res_ready(r_ready),
    .m_axis_res_last(r_last), .o_err_len(err)
  );

  mat_accum_pp #(.ACC_W(8), .SATURATE(1)) dut_sat8 (
    .i_clk(clk), .i_clk_e(clk_e), .i_rst_n(rst_n),
    .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_ready(s_ready_a), .s_axis_last(s_last),
    .m_axis_res_data(r_data_a), .m_axis_res_valid(r_valid_a), .m_axis_res_ready(r_ready),
    .m_axis_res_last(r_last_a), .o_err_len(err_a)
  );

  mat_accum_pp #(.ACC_W(8), .SATURATE(0)) dut_wrap8 (
    .i_clk(clk), .i_clk_e(clk_e), .i_rst_n(rst_n),
    .s_axis_data(s_data), .s_axis_valid(s_valid), .s_axis_ready(s_ready_b), .s_axis_last(s_last),
    .m_axis_res_data(r_data_b), .m_axis_res_valid(r_valid_b), .m_axis_res_ready(r_ready),
    .m_axis_res_last(r_last_b), .o_err_len(err_b)
  );

  int in_d[$];
  bit in_l[$];
  integer exp16[$], exp8s[$], exp8w[$];
  integer got16[$], got8s[$], got8w[$];
  bit got_l[$];
  int compared = 0, mismatched = 0, out_cnt = 0;
  int ce_pct = 100, gap_pct = 0, rdy_pct = 100;

  // Value of v stored in a w-bit signed word, clamped or wrapped
  function automatic int fit(input longint v, input int w, input bit sat);
    longint hi, lo, m;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    if (sat) begin
      if (v > hi) return int'(hi);
      if (v < lo) return int'(lo);
      return int'(v);
    end
    m = v & ((longint'(1) << w) - 1);
    if (m > hi) m = m - (longint'(1) << w);
    return int'(m);
  endfunction

  // Queue one batch of input beats and its expected result for all three instances
  task automatic add_batch(input int vals[NB], input int bad_pos);
    int a16, a8s, a8w;
    for (int i = 0; i < NB; i++) begin
      in_d.push_back(vals[i]);
      in_l.push_back((i % EL == EL - 1) || (i == bad_pos));
    end
    for (int e = 0; e < EL; e++) begin
      a16 = vals[e]; a8s = vals[e]; a8w = vals[e];
      for (int t = 1; t < NT; t++) begin
        a16 = fit(longint'(a16) + vals[t*EL+e], 16, 1'b1);
        a8s = fit(longint'(a8s) + vals[t*EL+e], 8, 1'b1);
        a8w = fit(longint'(a8w) + vals[t*EL+e], 8, 1'b0);
      end
      exp16.push_back(a16); exp8s.push_back(a8s); exp8w.push_back(a8w);
    end
  endtask

  task automatic add_const(input int c);
    int v[NB];
    foreach (v[i]) v[i] = c;
    add_batch(v, -1);
  endtask

  task automatic add_rand();
    int v[NB];
    foreach (v[i]) v[i] = int'($urandom_range(255)) - 128;
    add_batch(v, -1);
  endtask

  // Present n queued beats, honouring ready, with optional gaps and clock-enable drops
  task automatic drive(input int n, output bit ok);
    int v; bit l; int waited; bit done;
    ok = 1'b1;
    for (int k = 0; k < n; k++) begin
      v = in_d.pop_front(); l = in_l.pop_front(); waited = 0; done = 1'b0;
      while (!done) begin
        @(negedge clk);
        if (int'($urandom_range(99)) < gap_pct) begin
          s_valid = 1'b0;
        end else begin
          s_valid = 1'b1; s_data = 8'(v); s_last = l;
        end
        clk_e = (int'($urandom_range(99)) < ce_pct);
        #1;
        if (s_valid && s_ready && clk_e) begin
          done = 1'b1;
        end else if (++waited > 3000) begin
          compared++; mismatched++;
          $display("FAIL drive_timeout: beat %0d ready=%b required 1 within 3000 cycles", k, s_ready);
          ok = 1'b0;
          @(negedge clk); s_valid = 1'b0; s_last = 1'b0; clk_e = 1'b1;
          return;
        end
      end
    end
    @(negedge clk); s_valid = 1'b0; s_last = 1'b0; clk_e = 1'b1;
  endtask

  // Record n accepted output beats from all instances under random sink readiness
  task automatic collect(input int n, output bit ok);
    int got; int waited;
    ok = 1'b1; got = 0; waited = 0;
    while (got < n) begin
      @(negedge clk);
      r_ready = (int'($urandom_range(99)) < rdy_pct);
      #1;
      if (r_valid && r_ready && clk_e) begin
        got16.push_back(r_data); got8s.push_back(r_data_a); got8w.push_back(r_data_b);
        got_l.push_back(r_last);
        got++; waited = 0;
      end else if (++waited > 3000) begin
        compared++; mismatched++;
        $display("FAIL collect_timeout: got %0d beats, required %0d", got, n);
        ok = 1'b0;
        break;
      end
    end
    @(negedge clk); r_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clk_e = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; r_ready = 1'b0;
    #12;
    compared++; if (s_ready !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b expected 1", s_ready); end
    compared++; if (r_valid !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b expected 0", r_valid); end
    compared++; if (r_last !== 1'b0) begin mismatched++; $display("FAIL reset_last: got %b expected 0", r_last); end
    compared++; if (r_data !== 16'sd0) begin mismatched++; $display("FAIL reset_data: got %0d expected 0", r_data); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL reset_err: got %b expected 0", err); end
    $display("reset: ready=%b valid=%b last=%b data=%0d err=%b", s_ready, r_valid, r_last, r_data, err);
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    bit ok; integer g16, g8s, g8w, e16, e8s, e8w; bit gl, el;
    add_const(5);
    drive(NB - 1, ok);
    compared++; if (r_valid !== 1'b0) begin mismatched++; $display("FAIL basic_early_valid: got %b expected 0", r_valid); end
    drive(1, ok);
    compared++;
    if (r_valid !== 1'b1 || r_data !== exp16[0] || r_last !== 1'b0) begin
      mismatched++; $display("FAIL basic_latency: valid=%b data=%0d last=%b expected 1/%0d/0", r_valid, r_data, r_last, exp16[0]);
    end
    collect(EL, ok);
    for (int i = 0; i < EL && got16.size() > 0; i++) begin
      g16 = got16.pop_front(); g8s = got8s.pop_front(); g8w = got8w.pop_front(); gl = got_l.pop_front();
      e16 = exp16.pop_front(); e8s = exp8s.pop_front(); e8w = exp8w.pop_front();
      el = (out_cnt % EL == EL - 1); out_cnt++; compared++;
      $display("basic[%0d]: %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl);
      if (g16 !== e16 || g8s !== e8s || g8w !== e8w || gl !== el) begin
        mismatched++; $display("FAIL basic[%0d]: got %0d/%0d/%0d last=%b expected %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl, e16, e8s, e8w, el);
      end
    end
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL basic_err: got %b expected 0", err); end
  endtask

  task automatic test_saturation();
    bit ok; integer g16, g8s, g8w, e16, e8s, e8w; bit gl, el;
    add_const(127); add_const(-128);
    drive(2 * NB, ok);
    collect(2 * EL, ok);
    for (int i = 0; i < 2 * EL && got16.size() > 0; i++) begin
      g16 = got16.pop_front(); g8s = got8s.pop_front(); g8w = got8w.pop_front(); gl = got_l.pop_front();
      e16 = exp16.pop_front(); e8s = exp8s.pop_front(); e8w = exp8w.pop_front();
      el = (out_cnt % EL == EL - 1); out_cnt++; compared++;
      $display("sat[%0d]: %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl);
      if (g16 !== e16 || g8s !== e8s || g8w !== e8w || gl !== el) begin
        mismatched++; $display("FAIL sat[%0d]: got %0d/%0d/%0d last=%b expected %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl, e16, e8s, e8w, el);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2; integer g16, g8s, g8w, e16, e8s, e8w; bit gl, el;
    r_ready = 1'b0;
    add_rand(); add_rand();
    drive(2 * NB, ok1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      compared++;
      if (s_ready !== 1'b0 || r_valid !== 1'b1 || r_data !== exp16[0]) begin
        mismatched++; $display("FAIL stall[%0d]: ready=%b valid=%b data=%0d expected 0/1/%0d", c, s_ready, r_valid, r_data, exp16[0]);
      end
    end
    add_rand();
    rdy_pct = 70;
    fork
      drive(NB, ok1);
      collect(3 * EL, ok2);
    join
    rdy_pct = 100;
    for (int i = 0; i < 3 * EL && got16.size() > 0; i++) begin
      g16 = got16.pop_front(); g8s = got8s.pop_front(); g8w = got8w.pop_front(); gl = got_l.pop_front();
      e16 = exp16.pop_front(); e8s = exp8s.pop_front(); e8w = exp8w.pop_front();
      el = (out_cnt % EL == EL - 1); out_cnt++; compared++;
      $display("b2b[%0d]: %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl);
      if (g16 !== e16 || g8s !== e8s || g8w !== e8w || gl !== el) begin
        mismatched++; $display("FAIL b2b[%0d]: got %0d/%0d/%0d last=%b expected %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl, e16, e8s, e8w, el);
      end
    end
  endtask

  task automatic test_simultaneous();
    bit ok; integer g16, g8s, g8w, e16, e8s, e8w; bit gl, el;
    r_ready = 1'b0;
    add_rand(); add_rand();
    drive(NB, ok);
    drive(NB - 1, ok);
    collect(EL - 1, ok);
    @(negedge clk);
    s_valid = 1'b1; s_data = 8'(in_d.pop_front()); s_last = in_l.pop_front(); r_ready = 1'b1; clk_e = 1'b1;
    #1;
    g16 = r_data; gl = r_last;
    compared++;
    if (s_ready !== 1'b1 || r_valid !== 1'b1) begin
      mismatched++; $display("FAIL simul_pre: ready=%b valid=%b expected 1/1", s_ready, r_valid);
    end
    got16.push_back(g16); got8s.push_back(r_data_a); got8w.push_back(r_data_b); got_l.push_back(gl);
    for (int i = 0; i < EL && got16.size() > 0; i++) begin
      g16 = got16.pop_front(); g8s = got8s.pop_front(); g8w = got8w.pop_front(); gl = got_l.pop_front();
      e16 = exp16.pop_front(); e8s = exp8s.pop_front(); e8w = exp8w.pop_front();
      el = (out_cnt % EL == EL - 1); out_cnt++; compared++;
      $display("simA[%0d]: %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl);
      if (g16 !== e16 || g8s !== e8s || g8w !== e8w || gl !== el) begin
        mismatched++; $display("FAIL simA[%0d]: got %0d/%0d/%0d last=%b expected %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl, e16, e8s, e8w, el);
      end
    end
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; r_ready = 1'b0;
    #1;
    compared++;
    if (s_ready !== 1'b1 || r_valid !== 1'b1 || r_data !== exp16[0]) begin
      mismatched++; $display("FAIL simul_post: ready=%b valid=%b data=%0d expected 1/1/%0d", s_ready, r_valid, r_data, exp16[0]);
    end
    collect(EL, ok);
    for (int i = 0; i < EL && got16.size() > 0; i++) begin
      g16 = got16.pop_front(); g8s = got8s.pop_front(); g8w = got8w.pop_front(); gl = got_l.pop_front();
      e16 = exp16.pop_front(); e8s = exp8s.pop_front(); e8w = exp8w.pop_front();
      el = (out_cnt % EL == EL - 1); out_cnt++; compared++;
      $display("simB[%0d]: %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl);
      if (g16 !== e16 || g8s !== e8s || g8w !== e8w || gl !== el) begin
        mismatched++; $display("FAIL simB[%0d]: got %0d/%0d/%0d last=%b expected %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl, e16, e8s, e8w, el);
      end
    end
  endtask

  task automatic test_framing();
    bit ok; int v[NB]; integer g16, g8s, g8w, e16, e8s, e8w; bit gl, el;
    foreach (v[i]) v[i] = int'($urandom_range(255)) - 128;
    add_batch(v, 4);
    drive(4, ok);
    compared++; if (err !== 1'b0) begin mismatched++; $display("FAIL framing_before: got %b expected 0", err); end
    drive(1, ok);
    compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL framing_set: got %b expected 1", err); end
    drive(NB - 5, ok);
    collect(EL, ok);
    for (int i = 0; i < EL && got16.size() > 0; i++) begin
      g16 = got16.pop_front(); g8s = got8s.pop_front(); g8w = got8w.pop_front(); gl = got_l.pop_front();
      e16 = exp16.pop_front(); e8s = exp8s.pop_front(); e8w = exp8w.pop_front();
      el = (out_cnt % EL == EL - 1); out_cnt++; compared++;
      $display("frame[%0d]: %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl);
      if (g16 !== e16 || g8s !== e8s || g8w !== e8w || gl !== el) begin
        mismatched++; $display("FAIL frame[%0d]: got %0d/%0d/%0d last=%b expected %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl, e16, e8s, e8w, el);
      end
    end
    compared++; if (err !== 1'b1) begin mismatched++; $display("FAIL framing_sticky: got %b expected 1", err); end
  endtask

  task automatic test_random();
    bit ok1, ok2; integer g16, g8s, g8w, e16, e8s, e8w; bit gl, el;
    ce_pct = 60; gap_pct = 30; rdy_pct = 60;
    for (int b = 0; b < 4; b++) add_rand();
    fork
      drive(4 * NB, ok1);
      collect(4 * EL, ok2);
    join
    ce_pct = 100; gap_pct = 0; rdy_pct = 100;
    for (int i = 0; i < 4 * EL && got16.size() > 0; i++) begin
      g16 = got16.pop_front(); g8s = got8s.pop_front(); g8w = got8w.pop_front(); gl = got_l.pop_front();
      e16 = exp16.pop_front(); e8s = exp8s.pop_front(); e8w = exp8w.pop_front();
      el = (out_cnt % EL == EL - 1); out_cnt++; compared++;
      $display("rand[%0d]: %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl);
      if (g16 !== e16 || g8s !== e8s || g8w !== e8w || gl !== el) begin
        mismatched++; $display("FAIL rand[%0d]: got %0d/%0d/%0d last=%b expected %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl, e16, e8s, e8w, el);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit ok; integer g16, g8s, g8w, e16, e8s, e8w; bit gl, el;
    r_ready = 1'b0;
    add_rand(); add_rand();
    drive(NB, ok);
    drive(13, ok);
    compared++;
    if (r_valid !== 1'b1 || s_ready !== 1'b1 || err !== 1'b1) begin
      mismatched++; $display("FAIL premid_state: valid=%b ready=%b err=%b expected 1/1/1", r_valid, s_ready, err);
    end
    #2 rst_n = 1'b0;
    #1;
    compared++;
    if (r_valid !== 1'b0 || s_ready !== 1'b1 || r_last !== 1'b0 || r_data !== 16'sd0 || err !== 1'b0) begin
      mismatched++; $display("FAIL midreset_state: valid=%b ready=%b last=%b data=%0d err=%b expected 0/1/0/0/0", r_valid, s_ready, r_last, r_data, err);
    end
    $display("midreset: valid=%b ready=%b err=%b", r_valid, s_ready, err);
    in_d.delete(); in_l.delete(); exp16.delete(); exp8s.delete(); exp8w.delete(); out_cnt = 0;
    @(negedge clk); rst_n = 1'b1;
    add_const(1);
    drive(NB, ok);
    collect(EL, ok);
    for (int i = 0; i < EL && got16.size() > 0; i++) begin
      g16 = got16.pop_front(); g8s = got8s.pop_front(); g8w = got8w.pop_front(); gl = got_l.pop_front();
      e16 = exp16.pop_front(); e8s = exp8s.pop_front(); e8w = exp8w.pop_front();
      el = (out_cnt % EL == EL - 1); out_cnt++; compared++;
      $display("ones[%0d]: %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl);
      if (g16 !== e16 || g8s !== e8s || g8w !== e8w || gl !== el) begin
        mismatched++; $display("FAIL ones[%0d]: got %0d/%0d/%0d last=%b expected %0d/%0d/%0d last=%b", i, g16, g8s, g8w, gl, e16, e8s, e8w, el);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturation();
    test_back_to_back();
    test_simultaneous();
    test_framing();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 50000 cycles");
    $fatal(1, "global timeout");
  end

endmodule
